// File: rtl/cam_cfg_pkg.sv
// -----------------------------------------------------------------------------
// cam_cfg_pkg
// Shared definitions for the OV7670 configuration sequencer:
//   - cfg_state_e : sequencer state encoding
//   - CFG_END / CFG_DELAY : table marker entries
//   - OV7670 register address constants used by the configuration table
//   - small constant helpers for counter sizing and terminal counts
// -----------------------------------------------------------------------------
package cam_cfg_pkg;

    typedef enum logic [2:0] {
        ST_STARTUP   = 3'd0,
        ST_FETCH     = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_WAIT_BUSY = 3'd3,
        ST_GAP       = 3'd4,
        ST_DELAY     = 3'd5,
        ST_DONE      = 3'd6,
        ST_ERROR     = 3'd7
    } cfg_state_e;

    // Table markers: neither value is a meaningful register write.
    localparam logic [15:0] CFG_END   = 16'hFFFF;
    localparam logic [15:0] CFG_DELAY = 16'hFFF0;

    // OV7670 register addresses
    localparam logic [7:0] REG_VREF   = 8'h03;
    localparam logic [7:0] REG_COM3   = 8'h0C;
    localparam logic [7:0] REG_CLKRC  = 8'h11;
    localparam logic [7:0] REG_COM7   = 8'h12;
    localparam logic [7:0] REG_HSTART = 8'h17;
    localparam logic [7:0] REG_HSTOP  = 8'h18;
    localparam logic [7:0] REG_VSTART = 8'h19;
    localparam logic [7:0] REG_VSTOP  = 8'h1A;
    localparam logic [7:0] REG_HREF   = 8'h32;
    localparam logic [7:0] REG_TSLB   = 8'h3A;
    localparam logic [7:0] REG_COM14  = 8'h3E;
    localparam logic [7:0] REG_COM15  = 8'h40;
    localparam logic [7:0] REG_RGB444 = 8'h8C;

    function automatic logic [15:0] cfg_entry(input logic [7:0] addr, input logic [7:0] data);
        return {addr, data};
    endfunction

    // Terminal count for an N-cycle wait that starts counting at 0.
    // A requested length of 0 still spends one cycle in the waiting state.
    function automatic int last_cnt(input int n);
        return (n > 1) ? n - 1 : 0;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cam_config_rom.sv
// -----------------------------------------------------------------------------
// cam_config_rom
// Combinational OV7670 configuration table: soft reset, settle delay, then an
// RGB565 / QVGA register set, terminated by an end marker. Any index beyond
// the table returns the end marker.
// Ports:
//   index : table index (IDX_W bits)
//   entry : 16-bit {address, data}, or CFG_DELAY / CFG_END marker
// -----------------------------------------------------------------------------
module cam_config_rom #(
    parameter int IDX_W = 7
) (
    input  logic [IDX_W-1:0] index,
    output logic [15:0]      entry
);
    import cam_cfg_pkg::*;

    always_comb begin
        entry = CFG_END;
        case (int'(index))
            0:       entry = cfg_entry(REG_COM7,   8'h80); // soft reset
            1:       entry = CFG_DELAY;                    // let the sensor settle
            2:       entry = cfg_entry(REG_COM7,   8'h14); // QVGA, RGB output
            3:       entry = cfg_entry(REG_CLKRC,  8'h01);
            4:       entry = cfg_entry(REG_COM15,  8'hD0); // RGB565, full range
            5:       entry = cfg_entry(REG_TSLB,   8'h04);
            6:       entry = cfg_entry(REG_RGB444, 8'h00); // RGB444 off
            7:       entry = cfg_entry(REG_COM3,   8'h00);
            8:       entry = cfg_entry(REG_COM14,  8'h00);
            9:       entry = cfg_entry(REG_HSTART, 8'h16);
            10:      entry = cfg_entry(REG_HSTOP,  8'h04);
            11:      entry = cfg_entry(REG_HREF,   8'h24);
            12:      entry = cfg_entry(REG_VSTART, 8'h02);
            13:      entry = cfg_entry(REG_VSTOP,  8'h7A);
            14:      entry = cfg_entry(REG_VREF,   8'h0A);
            15:      entry = CFG_END;
            default: entry = CFG_END;
        endcase
    end

endmodule

// File: rtl/cam_config_sequencer.sv
// -----------------------------------------------------------------------------
// cam_config_sequencer
// Walks the OV7670 configuration table and hands each {address, data} pair to
// the SCCB writer with an enable/busy handshake. Waits STARTUP_CYCLES after
// reset, honours delay markers, stops at the end marker (or the last table
// slot) and raises config_done.
//
// Optional feature (macro CAM_CFG_TIMEOUT_EN): a per-write watchdog. If one
// write stays in ISSUE/WAIT_BUSY for BUSY_TIMEOUT cycles, enable is dropped,
// cfg_error latches and the sequencer parks in ERROR until start.
// Without the macro, cfg_error is tied low and busy is waited on forever.
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : pulse; re-runs the table from index 0 (DONE/ERROR only)
//   sccb_busy    : writer busy flag
//   sccb_enable  : write request, held for the whole transaction
//   reg_address  : register address of current write
//   reg_data     : register value of current write
//   config_done  : table fully written
//   cfg_index    : current table index
//   cfg_error    : write timed out
// -----------------------------------------------------------------------------
module cam_config_sequencer #(
    parameter int STARTUP_CYCLES = 1_000_000,
    parameter int GAP_CYCLES     = 256,
    parameter int DELAY_CYCLES   = 250_000,
    parameter int ROM_DEPTH      = 128,
    parameter int IDX_W          = $clog2(ROM_DEPTH),
    parameter int BUSY_TIMEOUT   = 4096
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sccb_busy,
    output logic             sccb_enable,
    output logic [7:0]       reg_address,
    output logic [7:0]       reg_data,
    output logic             config_done,
    output logic [IDX_W-1:0] cfg_index,
    output logic             cfg_error
);
    import cam_cfg_pkg::*;

    // One shared counter serves every wait, so it is sized for the longest.
    localparam int CNT_MAX = max_int(max_int(STARTUP_CYCLES, GAP_CYCLES),
                                     max_int(DELAY_CYCLES, BUSY_TIMEOUT));
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    cfg_state_e       state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [IDX_W-1:0] idx_q,    idx_d;
    logic             enable_q, enable_d;
    logic [7:0]       addr_q,   addr_d;
    logic [7:0]       data_q,   data_d;
    logic             done_q,   done_d;
`ifdef CAM_CFG_TIMEOUT_EN
    logic             err_q,    err_d;
    logic             timeout_hit;
`endif

    logic [15:0] rom_entry;
    logic        is_last_slot;

    cam_config_rom #(
        .IDX_W (IDX_W)
    ) u_rom (
        .index (idx_q),
        .entry (rom_entry)
    );

    // The final slot ends the run whatever it holds, so the index never wraps.
    assign is_last_slot = (idx_q == IDX_W'(ROM_DEPTH - 1));

`ifdef CAM_CFG_TIMEOUT_EN
    assign timeout_hit = (int'(cnt_q) == last_cnt(BUSY_TIMEOUT));
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        enable_d = enable_q;
        addr_d   = addr_q;
        data_d   = data_q;
        done_d   = done_q;
`ifdef CAM_CFG_TIMEOUT_EN
        err_d    = err_q;
`endif
        case (state_q)
            ST_STARTUP: begin
                if (int'(cnt_q) == last_cnt(STARTUP_CYCLES)) begin
                    cnt_d   = '0;
                    state_d = ST_FETCH;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_FETCH: begin
                cnt_d = '0;
                if (rom_entry == CFG_END || is_last_slot) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else if (rom_entry == CFG_DELAY) begin
                    state_d = ST_DELAY;
                end else begin
                    // Address/data are latched here and left alone until the
                    // next FETCH, so they never move while enable is high.
                    addr_d   = rom_entry[15:8];
                    data_d   = rom_entry[7:0];
                    enable_d = 1'b1;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Busy already high on the first ISSUE cycle counts as the ack.
`ifdef CAM_CFG_TIMEOUT_EN
                cnt_d = cnt_q + CNT_W'(1);
                if (sccb_busy) begin
                    state_d = ST_WAIT_BUSY;
                end else if (timeout_hit) begin
                    enable_d = 1'b0;
                    err_d    = 1'b1;
                    state_d  = ST_ERROR;
                end
`else
                if (sccb_busy) begin
                    state_d = ST_WAIT_BUSY;
                end
`endif
            end
            ST_WAIT_BUSY: begin
                if (!sccb_busy) begin
                    enable_d = 1'b0;
                    idx_d    = idx_q + IDX_W'(1);
                    cnt_d    = '0;
                    state_d  = ST_GAP;
                end
`ifdef CAM_CFG_TIMEOUT_EN
                else if (timeout_hit) begin
                    enable_d = 1'b0;
                    err_d    = 1'b1;
                    state_d  = ST_ERROR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            ST_GAP: begin
                if (int'(cnt_q) == last_cnt(GAP_CYCLES)) begin
                    cnt_d   = '0;
                    state_d = ST_FETCH;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DELAY: begin
                if (int'(cnt_q) == last_cnt(DELAY_CYCLES)) begin
                    cnt_d   = '0;
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = ST_FETCH;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                // Re-run skips the power-up settle: the sensor is already up.
                if (start) begin
                    done_d  = 1'b0;
                    idx_d   = '0;
                    state_d = ST_FETCH;
                end
            end
`ifdef CAM_CFG_TIMEOUT_EN
            ST_ERROR: begin
                if (start) begin
                    err_d   = 1'b0;
                    idx_d   = '0;
                    state_d = ST_FETCH;
                end
            end
`endif
            default: begin
                state_d = ST_STARTUP;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_STARTUP;
            cnt_q    <= '0;
            idx_q    <= '0;
            enable_q <= 1'b0;
            addr_q   <= 8'h00;
            data_q   <= 8'h00;
            done_q   <= 1'b0;
`ifdef CAM_CFG_TIMEOUT_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            enable_q <= enable_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            done_q   <= done_d;
`ifdef CAM_CFG_TIMEOUT_EN
            err_q    <= err_d;
`endif
        end
    end

    assign sccb_enable = enable_q;
    assign reg_address = addr_q;
    assign reg_data    = data_q;
    assign config_done = done_q;
    assign cfg_index   = idx_q;
`ifdef CAM_CFG_TIMEOUT_EN
    assign cfg_error   = err_q;
`else
    assign cfg_error   = 1'b0;
`endif

endmodule

// File: tb/tb_cam_config_sequencer.sv
module tb_cam_config_sequencer;
    localparam int STARTUP = 16;
    localparam int GAP     = 4;
    localparam int DELAY   = 32;
    localparam int DEPTH   = 128;
    localparam int TMO     = 64;
    localparam int IDX_W   = $clog2(DEPTH);
    localparam int BUDGET  = 5000;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             sccb_busy;
    logic             sccb_enable;
    logic [7:0]       reg_address;
    logic [7:0]       reg_data;
    logic             config_done;
    logic [IDX_W-1:0] cfg_index;
    logic             cfg_error;

    logic stuck = 1'b0;   // writer model holds busy high forever when set
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    cam_config_sequencer #(
        .STARTUP_CYCLES (STARTUP),
        .GAP_CYCLES     (GAP),
        .DELAY_CYCLES   (DELAY),
        .ROM_DEPTH      (DEPTH),
        .BUSY_TIMEOUT   (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .sccb_busy   (sccb_busy),
        .sccb_enable (sccb_enable),
        .reg_address (reg_address),
        .reg_data    (reg_data),
        .config_done (config_done),
        .cfg_index   (cfg_index),
        .cfg_error   (cfg_error)
    );

    // Expected table image: COM7 reset, delay marker, RGB565/QVGA set, end.
    logic [15:0] tbl [16];

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        int         idx;
        int         gap;   // enable-low cycles expected before this write
    } wr_t;

    wr_t exp_q[$];
    int  end_idx;

    // Reference model: list of writes the sequencer must emit, with the idle
    // time in front of each: GAP cycles + the FETCH cycle, plus DELAY cycles
    // and a FETCH cycle for every delay marker skipped on the way.
    function automatic void build_model();
        int  pending = 0;
        wr_t w;
        exp_q.delete();
        end_idx = -1;
        for (int i = 0; i < 16; i++) begin
            if (tbl[i] == 16'hFFFF) begin
                end_idx = i;
                return;
            end
            if (tbl[i] == 16'hFFF0) begin
                pending++;
            end else begin
                w.addr = tbl[i][15:8];
                w.data = tbl[i][7:0];
                w.idx  = i;
                w.gap  = (GAP + 1) + pending * (DELAY + 1);
                pending = 0;
                exp_q.push_back(w);
            end
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Waits (from the current negedge) for enable to rise, counting low cycles.
    task automatic expect_write(input wr_t w, input int gap);
        int low = 0;
        while (sccb_enable !== 1'b1 && low < BUDGET) begin
            low++;
            @(negedge clk);
        end
        check("gap_len", low, gap);
        check("addr", reg_address, w.addr);
        check("data", reg_data, w.data);
        check("index", cfg_index, w.idx);
        check("error_clear", cfg_error, 1'b0);
        $display("write idx=%0d addr=%02h data=%02h low_cycles=%0d (want %0d)",
                 cfg_index, reg_address, reg_data, low, gap);
    endtask

    // Follows the write until enable drops; address/data must not move.
    task automatic finish_write(input wr_t w);
        bit stable = 1'b1;
        int hi = 0;
        while (sccb_enable === 1'b1 && hi < BUDGET) begin
            if (reg_address !== w.addr || reg_data !== w.data) stable = 1'b0;
            hi++;
            @(negedge clk);
        end
        check("stable", stable, 1'b1);
        check("enable_drop", sccb_enable, 1'b0);
    endtask

    // SCCB writer model: acks after 0-2 cycles, stays busy 3-20 cycles.
    initial begin
        int n;
        sccb_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sccb_busy = 1'b0;
            end else if (stuck) begin
                if (sccb_enable) sccb_busy = 1'b1;
            end else if (sccb_enable && !sccb_busy) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                sccb_busy = 1'b1;
                n = $urandom_range(3, 20);
                for (int k = 0; k < n && rst_n; k++) @(negedge clk);
                sccb_busy = 1'b0;
                for (int k = 0; k < 8 && sccb_enable && rst_n; k++) @(negedge clk);
            end else begin
                sccb_busy = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int low;
        tbl = '{16'h1280, 16'hFFF0, 16'h1214, 16'h1101, 16'h40D0, 16'h3A04,
                16'h8C00, 16'h0C00, 16'h3E00, 16'h1716, 16'h1804, 16'h3224,
                16'h1902, 16'h1A7A, 16'h030A, 16'hFFFF};
        build_model();

        // Reset state
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_enable", sccb_enable, 1'b0);
        check("rst_addr", reg_address, 8'h00);
        check("rst_data", reg_data, 8'h00);
        check("rst_done", config_done, 1'b0);
        check("rst_index", cfg_index, 0);
        check("rst_error", cfg_error, 1'b0);

        // Full table after power-up; a start pulse mid-run must be ignored.
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < exp_q.size(); k++) begin
            expect_write(exp_q[k], (k == 0) ? STARTUP : exp_q[k].gap);
            if (k == 4) begin
                @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            finish_write(exp_q[k]);
        end

        // End marker: done one cycle after the FETCH that reads it.
        low = 0;
        while (config_done !== 1'b1 && low < BUDGET) begin
            low++;
            @(negedge clk);
        end
        check("done_gap", low, GAP + 1);
        check("done_index", cfg_index, end_idx);
        check("done_enable", sccb_enable, 1'b0);
        check("done_addr_held", reg_address, exp_q[exp_q.size()-1].addr);
        check("done_data_held", reg_data, exp_q[exp_q.size()-1].data);
        repeat (5) @(negedge clk);
        check("done_hold", config_done, 1'b1);
        check("done_no_enable", sccb_enable, 1'b0);

        // Restart from DONE: no startup wait.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("restart_done_drop", config_done, 1'b0);
        check("restart_index", cfg_index, 0);
        expect_write(exp_q[0], 1);
        finish_write(exp_q[0]);
        expect_write(exp_q[1], exp_q[1].gap);

        // Asynchronous reset while enable is high.
        #2 rst_n = 1'b0;
        #1;
        check("arst_enable", sccb_enable, 1'b0);
        check("arst_addr", reg_address, 8'h00);
        check("arst_data", reg_data, 8'h00);
        check("arst_done", config_done, 1'b0);
        check("arst_index", cfg_index, 0);
        check("arst_error", cfg_error, 1'b0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        expect_write(exp_q[0], STARTUP);
        finish_write(exp_q[0]);

`ifdef CAM_CFG_TIMEOUT_EN
        // Writer holds busy forever: watchdog drops enable after TMO cycles.
        stuck = 1'b1;
        expect_write(exp_q[1], exp_q[1].gap);
        low = 0;
        while (sccb_enable === 1'b1 && low < BUDGET) begin
            low++;
            @(negedge clk);
        end
        check("tmo_enable_len", low, TMO);
        check("tmo_error", cfg_error, 1'b1);
        check("tmo_done", config_done, 1'b0);
        repeat (3) @(negedge clk);
        check("tmo_sticky", cfg_error, 1'b1);
        check("tmo_enable_low", sccb_enable, 1'b0);
        stuck = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        expect_write(exp_q[0], 1);
        finish_write(exp_q[0]);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
